// File: rtl/alu_cmd_issuer_pkg.sv
// rtl/alu_cmd_issuer_pkg.sv - shared constants, opcode and state types for the ALU command issuer
// Contents: OPW (opcode width), RES_SAMPLE / ZERO_SAMPLE (sample-counter
// values), state_e {IDLE, RUN, RESP}, OP_ADD.
package alu_if_pkg;

    localparam int OPW = 2;

    // Sample-counter values inside RUN. The counter is cleared on pop, so
    // RES_SAMPLE is the 2nd edge after the pop and ZERO_SAMPLE the 3rd.
    localparam logic [1:0] RES_SAMPLE  = 2'd1;
    localparam logic [1:0] ZERO_SAMPLE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [OPW-1:0] OP_ADD = 2'b00;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// rtl/alu_cmd_issuer_if.sv - command, ALU and response signal bundle for the ALU command issuer
// Signals:
//   cmd_*  command request stream (valid/ready)
//   alu_*  operand/opcode to the ALU and result/carry/zero back from it
//   rsp_*  tagged response stream (valid/ready)
// Modports:
//   master  the issuer side
//   slave   the environment side (command source, ALU and response sink)
interface alu_cmd_if #(
    parameter int WIDTH = 4,
    parameter int TAGW  = 4
) ();
    import alu_if_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [OPW-1:0]   cmd_op;
    logic [TAGW-1:0]  cmd_tag;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic [TAGW-1:0]  rsp_tag;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_carry, alu_zero,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_tag,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_carry, alu_zero,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_tag,
        output rsp_ready
    );

endinterface

// File: rtl/alu_cmd_issuer_fifo.sv
// rtl/alu_cmd_issuer_fifo.sv - synchronous command FIFO with full/empty flags
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en, wr_data      write request and entry (ignored while full)
//   rd_en, rd_data      read request (ignored while empty); rd_data shows the head
//   full, empty         flags derived from the registered occupancy count
module cmd_fifo #(
    parameter int W     = 14,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - queues ALU commands, issues them to a registered ALU and returns tagged responses
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   bus          alu_cmd_if.master: cmd_* in, alu_* out/in, rsp_* out
//   idle         FIFO empty, FSM idle and no response pending
//   op_count     completed responses, wraps at 256
module alu_cmd_issuer
    import alu_if_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic      clk,
    input  logic      reset,
    alu_cmd_if.master bus,
    output logic      idle,
    output logic [7:0] op_count
);
    localparam int EW = 2*WIDTH + OPW + TAGW;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]       state;
    logic [1:0]       cnt;
    logic [TAGW-1:0]  tag_r;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [EW-1:0]    head;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic [OPW-1:0]   head_op;
    logic [TAGW-1:0]  head_tag;

    assign bus.cmd_ready = !full;
    assign push          = bus.cmd_valid && !full;

    // empty comes from the registered count, so a command pushed at this
    // edge cannot be popped until the next one.
    assign pop = !empty && ((state == ST_IDLE) ||
                            (state == ST_RESP && bus.rsp_ready));

    assign {head_a, head_b, head_op, head_tag} = head;

    cmd_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (push),
        .wr_data ({bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign idle = empty && (state == ST_IDLE) && !bus.rsp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            tag_r          <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            bus.alu_op     <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            bus.rsp_tag    <= '0;
            op_count       <= '0;
        end else begin
            // Operands change only here, so they stay stable until the next pop.
            if (pop) begin
                bus.alu_a  <= head_a;
                bus.alu_b  <= head_b;
                bus.alu_op <= head_op;
                tag_r      <= head_tag;
                cnt        <= '0;
            end
            case (state)
                ST_IDLE: begin
                    if (pop) state <= ST_RUN;
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    // Carry is captured exactly once; the ALU may feed it back.
                    if (cnt == RES_SAMPLE) begin
                        bus.rsp_result <= bus.alu_result;
                        bus.rsp_carry  <= bus.alu_carry;
                    end
                    // The ALU registers zero from its own registered result,
                    // so it is valid one edge after result/carry.
                    if (cnt == ZERO_SAMPLE) begin
                        bus.rsp_zero  <= bus.alu_zero;
                        bus.rsp_tag   <= tag_r;
                        bus.rsp_valid <= 1'b1;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        op_count      <= op_count + 1'b1;
                        state         <= pop ? ST_RUN : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - self-checking bench for alu_cmd_issuer with a registered ALU model
module tb_alu_cmd_issuer;
    import alu_if_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int TAGW  = 4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] tag;
    } cmd_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       idle;
    logic [7:0] op_count;

    alu_cmd_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();

    alu_cmd_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .idle     (idle),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    cmd_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   pushes = 0;
    bit   rand_ready = 0;

    // Reference ALU: 00 add, 01 sub (borrow in carry), 10 and, 11 or.
    // Returns {result, carry, zero}.
    function automatic logic [5:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
        logic [4:0] s;
        case (op)
            2'b00:   s = {1'b0, a} + {1'b0, b};
            2'b01:   s = {1'b0, a} - {1'b0, b};
            2'b10:   s = {1'b0, a & b};
            default: s = {1'b0, a | b};
        endcase
        return {s[3:0], s[4], (s[3:0] == 4'd0)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Registered ALU: result/carry registered from the operands, zero
    // registered from the registered result.
    logic [5:0] alu_nxt;
    assign alu_nxt = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.alu_result <= '0;
            bus.alu_carry  <= 1'b0;
            bus.alu_zero   <= 1'b0;
        end else begin
            bus.alu_result <= alu_nxt[5:2];
            bus.alu_carry  <= alu_nxt[1];
            bus.alu_zero   <= (bus.alu_result == 4'd0);
        end
    end

    // Response scoreboard: while a response is presented it must match the
    // oldest outstanding command, and the ALU inputs must still hold it.
    always @(negedge clk) begin : mon
        cmd_t       c;
        logic [5:0] r;
        if (!reset && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", 32'd1, 32'd0);
            end else begin
                c = exp_q[0];
                r = alu_ref(c.a, c.b, c.op);
                chk("rsp_fields", {bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_tag},
                    {r[5:2], r[1], r[0], c.tag});
                chk("alu_hold", {bus.alu_a, bus.alu_b, bus.alu_op}, {c.a, c.b, c.op});
                if (bus.rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push(input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] op, input logic [3:0] tag);
        cmd_t c;
        int   guard = 0;
        c.a = a; c.b = b; c.op = op; c.tag = tag;
        if (rand_ready) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_tag = tag;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            guard++;
            if (guard > 100) begin
                chk("push_timeout", 32'd0, 32'd1);
                bus.cmd_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (rand_ready) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        exp_q.push_back(c);
        pushes++;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (idle && exp_q.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, {bus.cmd_ready, idle, op_count, bus.alu_a, bus.alu_b, bus.alu_op,
                  bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_tag},
            {1'b1, 1'b1, 29'd0});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ob;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0; bus.cmd_tag = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        #12;
        chk_reset_vals("reset_vals");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Single ADD: 9+8 -> result 1, carry 1, zero 0; valid 4 edges after acceptance
        push(4'd9, 4'd8, OP_ADD, 4'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("latency_p3", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("latency_p4", 32'(bus.rsp_valid), 32'd1);
        wait_drain(50);
        chk("op_count_1", 32'(op_count), 32'd1);

        // Zero path: 8+8 -> result 0, carry 1, zero 1 (previous zero was 0)
        push(4'd8, 4'd8, OP_ADD, 4'd7);
        wait_drain(50);
        chk("op_count_2", 32'(op_count), 32'd2);

        // Backpressure: stall one response, fill FIFO, then release
        bus.rsp_ready = 1'b0;
        push(4'($urandom), 4'($urandom), 2'($urandom), 4'd8);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
        for (int i = 0; i < DEPTH; i++)
            push(4'($urandom), 4'($urandom), 2'($urandom), 4'(9 + i));
        chk("bp_full_ready", 32'(bus.cmd_ready), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_hold_ready", 32'(bus.cmd_ready), 32'd0);
        ob = pushes - 5;
        bus.rsp_ready = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        chk("bp_rate_16", 32'(op_count), 32'((ob + 4) & 255));
        @(posedge clk); #1;
        chk("bp_rate_17", 32'(op_count), 32'((ob + 5) & 255));
        wait_drain(50);

        // Burst of 6 random commands, tags 0..5
        for (int i = 0; i < 6; i++)
            push(4'($urandom), 4'($urandom), 2'($urandom), 4'(i));
        wait_drain(100);
        chk("burst_op_count", 32'(op_count), 32'(pushes & 255));
        chk("burst_idle", 32'(idle), 32'd1);

        // Reset while RUN with 3 commands queued
        for (int i = 0; i < 4; i++)
            push(4'($urandom), 4'($urandom), 2'($urandom), 4'(i));
        #2;
        reset = 1'b1;
        exp_q.delete();
        pushes = 0;
        #1;
        chk_reset_vals("mid_run_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("flushed_idle", 32'(idle), 32'd1);
        push(4'd5, 4'd3, 2'b01, 4'd12);
        wait_drain(50);
        chk("post_reset_count", 32'(op_count), 32'd1);

        // Wrap: 260 commands after reset, random backpressure
        reset = 1'b1;
        exp_q.delete();
        pushes = 0;
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        rand_ready = 1;
        for (int i = 0; i < 260; i++)
            push(4'($urandom), 4'($urandom), 2'($urandom), 4'(i));
        rand_ready = 0;
        wait_drain(200);
        chk("wrap_op_count", 32'(op_count), 32'd4);
        chk("wrap_idle", 32'(idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

- Command-side initiator for the registered 4-bit ALU. It buffers operation requests (A, B, opcode, tag) in a small FIFO and drives them onto the ALU operand/opcode inputs.
- It holds each operand set stable for the ALU's fixed registered latency, then samples result/carry and the one-cycle-later zero flag.
- It returns them as a tagged response over a valid/ready handshake.
- It sits between the test/control logic and the ALU; the ALU shares the same clock and reset.

## Interface
Parameters:
- WIDTH, 4, operand/result width
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- TAGW, 4, command tag width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_a, cmd_b  in  WIDTH  operands
- cmd_op  in  2  opcode, passed through unmodified
- cmd_tag  in  TAGW  returned with response
- alu_a, alu_b  out  WIDTH  to ALU A/B
- alu_op  out  2  to ALU opcode
- alu_result  in  WIDTH  from ALU result
- alu_carry, alu_zero  in  1  from ALU carry/zero
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_result  out  WIDTH
- rsp_carry, rsp_zero  out  1
- rsp_tag  out  TAGW
- idle  out  1  FIFO empty, FSM in IDLE, rsp_valid low
- op_count  out  8  completed responses, wraps 255→0

## Operation
- Reset values (async, immediate):
  - FIFO empty; cmd_ready=1.
  - alu_a/alu_b/alu_op=0.
  - rsp_* = 0, rsp_valid=0; op_count=0; idle=1; FSM=IDLE.
- Push: cmd_valid & cmd_ready at a clock edge writes one FIFO entry.
  - cmd_ready = !full, with no dependence on a same-cycle pop.
  - A push while full is impossible by construction.
- FSM IDLE → RUN: at an edge with FIFO non-empty, pop the head and register it into alu_a/alu_b/alu_op and an internal tag register; sample counter ← 0.
- RUN: the counter increments every edge.
  - Edge with counter=1 (2nd edge after pop): capture alu_result → rsp_result and alu_carry → rsp_carry.
  - Edge with counter=2: capture alu_zero → rsp_zero and the tag → rsp_tag; set rsp_valid; go to RESP.
  - The zero flag is sampled one edge later because the ALU derives it from its own registered result.
  - Carry is sampled once only; it may feed back inside the ALU and must not be resampled.
- alu_a/alu_b/alu_op hold constant from the pop until the next pop.
- RESP: rsp_* stay stable while rsp_valid & !rsp_ready. At an edge with rsp_ready:
  - rsp_valid ← 0 and op_count += 1.
  - If the FIFO is non-empty, pop in the same edge and go directly to RUN (back-to-back); otherwise go to IDLE.
- Pop in RESP is decided on registered FIFO state. A command pushed at edge e is poppable at edge e+1 at the earliest; there is no push-to-pop bypass.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, and cmd_ready rises in the following cycle.
- FIFO pointers wrap modulo DEPTH; the count is DEPTH+1 states wide.
- Commands complete strictly in order; no command is dropped or duplicated.

## Timing
- Pop at edge e0: ALU registers operands at e1; result/carry captured at e2; zero captured and rsp_valid=1 after e3.
- Acceptance into an empty FIFO at edge p gives pop at p+1 and rsp_valid after p+4.
- With rsp_ready tied high: one response per 4 cycles; handshake at e4 coincides with the next pop.
- Reset mid-RUN or mid-RESP: the in-flight command and all queued commands are discarded, with no response. Outputs return to reset values asynchronously.

## Structure
- Shared package alu_if_pkg:
  - OPW=2.
  - RES_SAMPLE=1 and ZERO_SAMPLE=2 counter constants.
  - State enum {IDLE, RUN, RESP}.
  - Opcode constant OP_ADD=2'b00 for benches.
- One sub-module: cmd_fifo, a synchronous FIFO with width 2*WIDTH+2+TAGW, DEPTH entries, full/empty flags, and asynchronous active-high reset.
- The FSM, counter and response registers live in the top.

## Test plan
- Single ADD against the real ALU: push a=9, b=8, op=00, tag=3 → rsp_valid 4 cycles after acceptance with result=1, carry=1, zero=0, tag=3; op_count=1.
- Zero path: push a=8, b=8, op=00 → result=0, carry=1, zero=1. Verify zero is not taken from the stale previous value.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid → rsp_* unchanged, FIFO keeps filling, cmd_ready=0 after DEPTH further pushes; release → responses drain in order with one response per 4 cycles.
- Burst of 6 random commands, rsp_ready=1 → tags return in order 0..5, all fields match a bench ALU model; alu_* stable throughout each RUN; op_count=6, idle=1 at end.
- Assert reset in RUN with 3 commands queued → all outputs at reset values before the next edge, no response for flushed commands; a post-reset command completes normally.
- Wrap: 260 commands → op_count reads 4; FIFO pointers wrap without loss.
